// File: rtl/arm_shift_pkg.sv
// Shared constants, request record and golden reference for the ARM barrel shifter.
// shift_ref works on up to 64-bit data; the result sits in the low w bits with the carry on top.
package arm_shift_pkg;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  localparam int MAX_W     = 64;
  localparam int MAX_AMT_W = 16;

  typedef struct packed {
    logic [MAX_W-1:0]     data;
    logic                 carry;
    logic [1:0]           op;
    logic [MAX_AMT_W-1:0] amount;
    logic                 reg_mode;
  } shift_req_t;

  function automatic logic [64:0] shift_ref(input logic [63:0] data, input logic carry,
                                            input logic [1:0] op, input logic [15:0] amount,
                                            input logic reg_mode, input int w);
    logic [63:0] mask, d, r, fill;
    logic        c, msb;
    int          a, n;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    d    = data & mask;
    msb  = d[w-1];
    fill = msb ? mask : 64'd0;
    a    = int'(amount);
    n    = a % w;
    r    = d;
    c    = carry;
    if (!reg_mode) begin
      case (op)
        SHIFT_LSL: if (n != 0) begin r = (d << n) & mask; c = d[w-n]; end
        SHIFT_LSR: if (n == 0) begin r = 64'd0; c = msb; end
                   else begin r = d >> n; c = d[n-1]; end
        SHIFT_ASR: if (n == 0) begin r = fill; c = msb; end
                   else begin r = ((d >> n) | (fill & ~(mask >> n))) & mask; c = d[n-1]; end
        default:   if (n == 0) begin r = (d >> 1) | ({63'd0, carry} << (w-1)); c = d[0]; end
                   else begin r = ((d >> n) | (d << (w-n))) & mask; c = r[w-1]; end
      endcase
    end else if (a != 0) begin
      case (op)
        SHIFT_LSL: if (a < w) begin r = (d << a) & mask; c = d[w-a]; end
                   else begin r = 64'd0; c = (a == w) ? d[0] : 1'b0; end
        SHIFT_LSR: if (a < w) begin r = d >> a; c = d[a-1]; end
                   else begin r = 64'd0; c = (a == w) ? msb : 1'b0; end
        SHIFT_ASR: if (a < w) begin r = ((d >> a) | (fill & ~(mask >> a))) & mask; c = d[a-1]; end
                   else begin r = fill; c = msb; end
        default:   if (n == 0) begin r = d; c = msb; end
                   else begin r = ((d >> n) | (d << (w-n))) & mask; c = r[w-1]; end
      endcase
    end
    return {c, r};
  endfunction

endpackage

// File: rtl/arm_shift_slice.sv
// One valid/ready register slice, one cycle; a full slice accepts new data only when it drains
// the same cycle, so ready is combinational from the downstream ready.
module arm_shift_slice
  import arm_shift_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld_i,
  output logic          rdy_o,
  input  logic [PW-1:0] dat_i,
  output logic          vld_o,
  input  logic          rdy_i,
  output logic [PW-1:0] dat_o
);

  logic          vld_q, vld_d;
  logic [PW-1:0] dat_q, dat_d;
  logic          adv;

  assign adv = ~vld_q | rdy_i;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (adv) begin
      vld_d = vld_i;
      if (vld_i) dat_d = dat_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign rdy_o = adv;
  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/arm_shift_pipe.sv
// Pipelined ARM barrel shifter (LSL/LSR/ASR/ROR/RRX), latency STAGES cycles, 1 result/cycle;
// in_ready is the stage-0 advance condition, derived combinationally from out_ready.
module arm_shift_pipe
  import arm_shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int AMT_W  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] shift_in,
  input  logic             carry_in,
  input  logic [1:0]       shift_op,
  input  logic [AMT_W-1:0] shift_amount,
  input  logic             reg_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] shift_out,
  output logic             carry_out
);

  localparam int LG = $clog2(WIDTH);
  localparam int VW = 2*WIDTH + 1;
  localparam int PW = VW + LG + 1;
  localparam logic [AMT_W-1:0] A_W = AMT_W'(WIDTH);

  // Every op becomes a right shift by s (< WIDTH) of {hi, lo, guard}; the result window is
  // bits [WIDTH:1], with the carry at bit 0 (shifted-out / fixed) or WIDTH+1 (LSL).
  logic [WIDTH-1:0] hi, lo, fill;
  logic [LG-1:0]    s, n;
  logic             guard, use_hi, sgn;

  assign n    = shift_amount[LG-1:0];
  assign sgn  = shift_in[WIDTH-1];
  assign fill = {WIDTH{sgn}};

  always_comb begin
    hi     = '0;
    lo     = shift_in;
    guard  = carry_in;
    s      = '0;
    use_hi = 1'b0;
    if (!reg_mode) begin
      case (shift_op)
        SHIFT_LSL: if (n != '0) begin hi = shift_in; lo = '0; s = ~n + LG'(1); use_hi = 1'b1; end
        SHIFT_LSR: if (n == '0) begin lo = '0; guard = sgn; end
                   else s = n;
        SHIFT_ASR: begin
          hi = fill;
          if (n == '0) begin lo = fill; guard = sgn; end
          else s = n;
        end
        default:   if (n == '0) begin hi = {{(WIDTH-1){1'b0}}, carry_in}; s = LG'(1); end
                   else begin hi = shift_in; s = n; end
      endcase
    end else if (shift_amount != '0) begin
      case (shift_op)
        SHIFT_LSL: if (shift_amount < A_W) begin
                     hi = shift_in; lo = '0; s = ~n + LG'(1); use_hi = 1'b1;
                   end else begin
                     lo = '0; guard = (shift_amount == A_W) & shift_in[0];
                   end
        SHIFT_LSR: if (shift_amount < A_W) s = n;
                   else begin lo = '0; guard = (shift_amount == A_W) & sgn; end
        SHIFT_ASR: begin
          hi = fill;
          if (shift_amount < A_W) s = n;
          else begin lo = fill; guard = sgn; end
        end
        default:   if (n == '0) guard = sgn;
                   else begin hi = shift_in; s = n; end
      endcase
    end
  end

  logic [PW-1:0]   stg_dat [0:STAGES];
  logic [STAGES:0] vld, rdy;

  assign stg_dat[0]  = {use_hi, s, hi, lo, guard};
  assign vld[0]      = in_valid;
  assign in_ready    = rdy[0];
  assign rdy[STAGES] = out_ready;
  assign out_valid   = vld[STAGES];

  for (genvar j = 0; j < STAGES; j++) begin : g_stage
    localparam int L_LO = j * LG / STAGES;
    localparam int L_HI = (j + 1) * LG / STAGES;
    logic [PW-1:0] lvl [L_LO:L_HI];

    assign lvl[L_LO] = stg_dat[j];
    for (genvar k = L_LO; k < L_HI; k++) begin : g_lvl
      assign lvl[k+1] = lvl[k][VW+k] ? {lvl[k][PW-1:VW], lvl[k][VW-1:0] >> (1 << k)} : lvl[k];
    end

    arm_shift_slice #(.PW(PW)) u_slice (
      .clk   (clk),
      .rst_n (rst_n),
      .vld_i (vld[j]),
      .rdy_o (rdy[j]),
      .dat_i (lvl[L_HI]),
      .vld_o (vld[j+1]),
      .rdy_i (rdy[j+1]),
      .dat_o (stg_dat[j+1])
    );
  end

  logic [PW-1:0] fin;
  logic          unused_fin;

  assign fin        = stg_dat[STAGES];
  assign shift_out  = fin[WIDTH:1];
  assign carry_out  = fin[PW-1] ? fin[WIDTH+1] : fin[0];
  assign unused_fin = ^fin[PW-2:WIDTH+2];

endmodule

// File: tb/tb_arm_shift_pipe.sv
// Self-checking bench for arm_shift_pipe (WIDTH=32, STAGES=2): vector table, sweep, stall,
// mid-stream reset and random handshake traffic, all checked through a result scoreboard.
module tb_arm_shift_pipe;
  import arm_shift_pkg::*;

  localparam int WIDTH  = 32;
  localparam int AMT_W  = 8;
  localparam int STAGES = 2;
  localparam logic [63:0] X = 64'habcdefab;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             in_valid = 1'b0, in_ready, carry_in = 1'b0, reg_mode = 1'b0;
  logic [WIDTH-1:0] shift_in = '0, shift_out;
  logic [1:0]       shift_op = 2'b00;
  logic [AMT_W-1:0] shift_amount = '0;
  logic             out_valid, out_ready, carry_out;
  logic             oready_set = 1'b1, rnd_mode = 1'b0, rnd_bit = 1'b0, lat_chk = 1'b0, drv_done = 1'b0;
  logic [64:0]      cur_exp = '0;
  int               cyc = 0, n_chk = 0, n_fail = 0, stall_cyc = 0;

  typedef struct { logic [64:0] exp; int cyc; } sb_t;
  typedef struct { shift_req_t req; logic [64:0] exp; } vec_t;
  sb_t  sb[$];
  vec_t tbl[$];

  arm_shift_pipe #(.WIDTH(WIDTH), .AMT_W(AMT_W), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .shift_in(shift_in), .carry_in(carry_in), .shift_op(shift_op),
    .shift_amount(shift_amount), .reg_mode(reg_mode), .out_valid(out_valid),
    .out_ready(out_ready), .shift_out(shift_out), .carry_out(carry_out)
  );

  assign out_ready = rnd_mode ? rnd_bit : oready_set;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) rnd_bit = ($urandom_range(0, 2) != 0);

  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    #2;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_out: got result %h with empty scoreboard, expected none", shift_out);
        end else begin
          e = sb.pop_front();
          check("result", {carry_out, 32'd0, shift_out}, e.exp);
          if (lat_chk) check("latency", 65'(cyc - e.cyc), 65'(STAGES));
        end
      end
      if (in_valid && in_ready) sb.push_back('{cur_exp, cyc});
    end
  end

  function automatic shift_req_t mk(logic [63:0] d, logic c, logic [1:0] op, logic [15:0] a, logic m);
    shift_req_t r;
    r.data = d; r.carry = c; r.op = op; r.amount = a; r.reg_mode = m;
    return r;
  endfunction

  function automatic vec_t mv(shift_req_t r, logic [31:0] d, logic c);
    vec_t v;
    v.req = r;
    v.exp = {c, 32'd0, d};
    return v;
  endfunction

  function automatic logic [64:0] ref_exp(shift_req_t r);
    return shift_ref(r.data, r.carry, r.op, r.amount, r.reg_mode, WIDTH);
  endfunction

  task automatic send(input shift_req_t r, input logic [64:0] e);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; shift_in = r.data[WIDTH-1:0]; carry_in = r.carry; shift_op = r.op;
    shift_amount = r.amount[AMT_W-1:0]; reg_mode = r.reg_mode; cur_exp = e;
    #3;
    while (!in_ready && t < 100) begin @(negedge clk); #3; t++; end
    stall_cyc += t;
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready 0 after %0d cycles, expected 1", t);
      in_valid = 1'b0;
    end else @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (sb.size() != 0 && t < 1000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    check(nm, 65'(sb.size()), 65'd0);
  endtask

  initial begin
    logic [64:0] hold;
    shift_req_t  r;

    tbl.push_back(mv(mk(X, 1, SHIFT_LSL, 4, 0),   32'hbcdefab0, 0));
    tbl.push_back(mv(mk(X, 1, SHIFT_ROR, 0, 0),   32'hd5e6f7d5, 1));
    tbl.push_back(mv(mk(X, 1, SHIFT_ASR, 0, 0),   32'hffffffff, 1));
    tbl.push_back(mv(mk(X, 1, SHIFT_LSR, 0, 0),   32'h00000000, 1));
    tbl.push_back(mv(mk(X, 1, SHIFT_LSL, 36, 0),  32'hbcdefab0, 0));
    tbl.push_back(mv(mk(X, 0, SHIFT_LSL, 0, 0),   32'habcdefab, 0));
    tbl.push_back(mv(mk(X, 0, SHIFT_LSR, 8, 0),   32'h00abcdef, 1));
    tbl.push_back(mv(mk(X, 0, SHIFT_ROR, 0, 0),   32'h55e6f7d5, 1));
    tbl.push_back(mv(mk(64'h7bcdefab, 0, SHIFT_ASR, 4, 0), 32'h07bcdefa, 1));
    tbl.push_back(mv(mk(X, 1, SHIFT_LSL, 32, 1),  32'h00000000, 1));
    tbl.push_back(mv(mk(X, 1, SHIFT_LSL, 33, 1),  32'h00000000, 0));
    tbl.push_back(mv(mk(X, 1, SHIFT_ASR, 40, 1),  32'hffffffff, 1));
    tbl.push_back(mv(mk(X, 1, SHIFT_ROR, 32, 1),  32'habcdefab, 1));
    for (int op = 0; op < 4; op++) tbl.push_back(mv(mk(X, 1, 2'(op), 0, 1), 32'habcdefab, 1));
    tbl.push_back(mv(mk(X, 0, SHIFT_LSR, 4, 1),   32'h0abcdefa, 1));
    tbl.push_back(mv(mk(X, 0, SHIFT_ROR, 36, 1),  32'hbabcdefa, 1));
    tbl.push_back(mv(mk(X, 0, SHIFT_ROR, 8, 1),   32'hababcdef, 1));
    tbl.push_back(mv(mk(X, 0, SHIFT_LSR, 32, 1),  32'h00000000, 1));
    tbl.push_back(mv(mk(X, 1, SHIFT_LSR, 255, 1), 32'h00000000, 0));
    tbl.push_back(mv(mk(X, 0, SHIFT_LSL, 31, 1),  32'h80000000, 1));

    // reset state
    #1;
    check("rst_out_valid", 65'(out_valid), 65'd0);
    check("rst_out_data", {carry_out, 32'd0, shift_out}, 65'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #3;
    check("rdy_after_rst", 65'(in_ready), 65'd1);

    // directed vectors, back to back, fixed latency
    lat_chk = 1'b1;
    foreach (tbl[i]) send(tbl[i].req, tbl[i].exp);
    idle();
    drain("table_drain");

    // full sweep against the reference, one per cycle
    stall_cyc = 0;
    for (int op = 0; op < 4; op++)
      for (int m = 0; m < 2; m++)
        for (int a = 0; a < 256; a++) begin
          r = mk(a[2] ? 64'h8421_7e5c : X, a[3], 2'(op), 16'(a), m[0]);
          send(r, ref_exp(r));
        end
    idle();
    check("sweep_no_stall", 65'(stall_cyc), 65'd0);
    drain("sweep_drain");
    lat_chk = 1'b0;

    // stall: two accepted, then in_ready low and output held
    @(negedge clk);
    oready_set = 1'b0;
    drv_done   = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(tbl[i].req, tbl[i].exp);
        idle();
        drv_done = 1'b1;
      end
    join_none
    repeat (3) @(negedge clk);
    #3;
    check("stall_in_ready", 65'(in_ready), 65'd0);
    check("stall_out_valid", 65'(out_valid), 65'd1);
    hold = {carry_out, 32'd0, shift_out};
    check("stall_head", hold, tbl[0].exp);
    repeat (2) begin
      @(negedge clk);
      #3;
      check("stall_hold", {carry_out, 32'd0, shift_out}, hold);
      check("stall_in_ready", 65'(in_ready), 65'd0);
    end
    @(negedge clk);
    oready_set = 1'b1;
    for (int t = 0; t < 100 && !drv_done; t++) @(negedge clk);
    check("stall_drv_done", 65'(drv_done), 65'd1);
    drain("stall_drain");

    // asynchronous reset with two in flight
    @(negedge clk);
    oready_set = 1'b0;
    send(tbl[4].req, tbl[4].exp);
    send(tbl[5].req, tbl[5].exp);
    idle();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 65'(out_valid), 65'd0);
    check("arst_out_data", {carry_out, 32'd0, shift_out}, 65'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    oready_set = 1'b1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #3;
      check("no_stale", 65'(out_valid), 65'd0);
    end
    check("rdy_after_arst", 65'(in_ready), 65'd1);
    lat_chk = 1'b1;
    send(tbl[6].req, tbl[6].exp);
    idle();
    drain("arst_drain");
    lat_chk = 1'b0;

    // random traffic with random backpressure
    rnd_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      r = mk({$urandom, $urandom}, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? 16'($urandom_range(28, 36)) : 16'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)));
      send(r, ref_exp(r));
    end
    idle();
    rnd_mode = 1'b0;
    drain("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
